button_conditioner: RTL and testbench

- Input-side companion to the LED counter on the DE0 board. It reads the raw push-buttons and slide switches and turns them into clean control signals for the counter: load strobes, direction toggles and step pulses.
- Per channel it provides a 2-FF synchronizer, a debounce filter, press/release edge pulses, a press-toggled state bit and hold-to-auto-repeat pulses.
- It sits between the board pins and counter-style datapaths, all in the single 50 MHz domain.

---
 rtl/button_pkg.sv | 35 +++
 rtl/debounce_channel.sv | 148 ++++++++++++++
 rtl/button_conditioner.sv | 38 +++
 tb/tb_button_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button / switch conditioning slice:
// default timing constants, repeat FSM encoding and width helpers.
package button_pkg;

    // 20 ms debounce, 0.5 s first repeat, 0.1 s repeat period at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
    localparam int unsigned DEF_REPEAT_DELAY    = 32'd25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 32'd5000000;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Ceiling log2, never below 1 so that counters always have at least one bit
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned width;
        width = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = 32'(i + 1);
            end
        end
        if (width == 32'd0) begin
            width = 32'd1;
        end
        return width;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input bit: 2-FF synchronizer, debounce filter, registered
// press/release pulses, press-toggled state and hold-to-repeat FSM.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle_state,
    output logic repeat_pulse
);

    localparam int unsigned DB_W  = clog2_min1(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_W = clog2_min1(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 32'd1);
    localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 32'd1);

    logic             sync1_r, sync2_r;
    logic [DB_W-1:0]  db_cnt_r, db_cnt_nxt_s;
    logic             level_r, level_nxt_s;
    logic             press_r, release_r, toggle_r, repeat_r;
    logic             rise_s, fall_s;
    rpt_state_e       rpt_state_r, rpt_state_nxt_s;
    logic [RPT_W-1:0] rpt_cnt_r, rpt_cnt_nxt_s;
    logic             rpt_fire_s;
    logic             sample_s;

    // Sample is taken only from the second synchronizer stage (1 = pressed)
    assign sample_s = ~sync2_r;

    // Bring the asynchronous pin into the clock domain; idle level is released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
        end
    end

    // Debounce decision: accept a new level only after an unbroken run of samples
    always_comb begin
        db_cnt_nxt_s = db_cnt_r;
        level_nxt_s  = level_r;
        if (sample_s == level_r) begin
            db_cnt_nxt_s = '0;
        end else if (db_cnt_r == DB_LAST) begin
            db_cnt_nxt_s = '0;
            level_nxt_s  = ~level_r;
        end else begin
            db_cnt_nxt_s = db_cnt_r + DB_W'(1);
        end
    end

    assign rise_s = level_nxt_s & ~level_r;
    assign fall_s = ~level_nxt_s & level_r;

    // Level, edge pulses and toggle all update on the edge that accepts the change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_r  <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            toggle_r  <= 1'b0;
        end else begin
            db_cnt_r  <= db_cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= rise_s;
            release_r <= fall_s;
            toggle_r  <= toggle_r ^ rise_s;
        end
    end

    // Repeat FSM next state; leaving on the upcoming level keeps repeats off release edges
    always_comb begin
        rpt_state_nxt_s = rpt_state_r;
        rpt_cnt_nxt_s   = rpt_cnt_r;
        rpt_fire_s      = 1'b0;
        case (rpt_state_r)
            RPT_IDLE: begin
                if (rise_s) begin
                    rpt_state_nxt_s = RPT_DELAY;
                    rpt_cnt_nxt_s   = '0;
                end else begin
                    rpt_cnt_nxt_s   = '0;
                end
            end
            RPT_DELAY: begin
                if (!level_nxt_s) begin
                    rpt_state_nxt_s = RPT_IDLE;
                    rpt_cnt_nxt_s   = '0;
                end else if (rpt_cnt_r == DELAY_LAST) begin
                    rpt_state_nxt_s = RPT_REPEAT;
                    rpt_cnt_nxt_s   = '0;
                    rpt_fire_s      = 1'b1;
                end else begin
                    rpt_cnt_nxt_s   = rpt_cnt_r + RPT_W'(1);
                end
            end
            RPT_REPEAT: begin
                if (!level_nxt_s) begin
                    rpt_state_nxt_s = RPT_IDLE;
                    rpt_cnt_nxt_s   = '0;
                end else if (rpt_cnt_r == PER_LAST) begin
                    rpt_cnt_nxt_s   = '0;
                    rpt_fire_s      = 1'b1;
                end else begin
                    rpt_cnt_nxt_s   = rpt_cnt_r + RPT_W'(1);
                end
            end
            default: begin
                rpt_state_nxt_s = RPT_IDLE;
                rpt_cnt_nxt_s   = '0;
            end
        endcase
    end

    // Repeat FSM state, shared delay/period counter and registered repeat pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_state_r <= RPT_IDLE;
            rpt_cnt_r   <= '0;
            repeat_r    <= 1'b0;
        end else begin
            rpt_state_r <= rpt_state_nxt_s;
            rpt_cnt_r   <= rpt_cnt_nxt_s;
            repeat_r    <= rpt_fire_s;
        end
    end

    assign level         = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign toggle_state  = toggle_r;
    assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_CH raw active-low buttons/switches into clean level,
// edge, toggle and auto-repeat controls for the LED counter.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned NUM_CH          = 32'd3,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] btn_n,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] toggle_state,
    output logic [NUM_CH-1:0] repeat_pulse
);

    for (genvar ch = 0; ch < int'(NUM_CH); ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk           (clk),
            .reset_n       (reset_n),
            .btn_n         (btn_n[ch]),
            .level         (level[ch]),
            .press_pulse   (press_pulse[ch]),
            .release_pulse (release_pulse[ch]),
            .toggle_state  (toggle_state[ch]),
            .repeat_pulse  (repeat_pulse[ch])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing constants.
module tb_button_conditioner;

    logic       clk;
    logic       reset_n;
    logic [2:0] btn_n;
    logic [2:0] level;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;
    logic [2:0] toggle_state;
    logic [2:0] repeat_pulse;

    int pass_cnt;
    int total_cnt;

    button_conditioner #(
        .NUM_CH          (3),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_n         (btn_n),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .toggle_state  (toggle_state),
        .repeat_pulse  (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge; inputs are driven and outputs sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_n   = 3'b111;
        #3;
        total_cnt++;
        if ({level, press_pulse, release_pulse, toggle_state, repeat_pulse} !== 15'd0)
            $display("FAIL reset_outputs got=%b exp=0", {level, press_pulse, release_pulse, toggle_state, repeat_pulse});
        else pass_cnt++;
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            total_cnt++;
            if ({level, press_pulse, release_pulse, toggle_state, repeat_pulse} !== 15'd0)
                $display("FAIL idle_outputs cycle=%0d got=%b exp=0", k, {level, press_pulse, release_pulse, toggle_state, repeat_pulse});
            else pass_cnt++;
        end
    endtask

    task automatic test_clean_press();
        btn_n[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            total_cnt++;
            if (level[0] !== 1'b0 || press_pulse[0] !== 1'b0)
                $display("FAIL press_early edge=%0d level=%b press=%b exp=0", k, level[0], press_pulse[0]);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if ({level[0], press_pulse[0], toggle_state[0]} !== 3'b111)
            $display("FAIL press_edge6 got=%b exp=111", {level[0], press_pulse[0], toggle_state[0]});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({level[0], press_pulse[0], toggle_state[0]} !== 3'b101)
            $display("FAIL press_one_cycle got=%b exp=101", {level[0], press_pulse[0], toggle_state[0]});
        else pass_cnt++;
        btn_n[0] = 1'b1;
        repeat (5) step();
        total_cnt++;
        if (level[0] !== 1'b1 || release_pulse[0] !== 1'b0)
            $display("FAIL release_early level=%b rel=%b exp=1/0", level[0], release_pulse[0]);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({level[0], release_pulse[0], toggle_state[0], repeat_pulse[0]} !== 4'b0110)
            $display("FAIL release_edge6 got=%b exp=0110", {level[0], release_pulse[0], toggle_state[0], repeat_pulse[0]});
        else pass_cnt++;
        step();
        total_cnt++;
        if (release_pulse[0] !== 1'b0)
            $display("FAIL release_one_cycle got=%b exp=0", release_pulse[0]);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic [8:0] pattern;
        // LSB first: 3 low, 2 high, 2 low, then high for the rest
        pattern = 9'b110011000;
        for (int k = 0; k < 20; k++) begin
            btn_n[0] = (k < 9) ? pattern[k] : 1'b1;
            step();
            total_cnt++;
            if ({level[0], press_pulse[0], toggle_state[0]} !== 3'b001)
                $display("FAIL bounce_reject k=%0d got=%b exp=001", k, {level[0], press_pulse[0], toggle_state[0]});
            else pass_cnt++;
        end
        // 2 low, 2 high, then steady low
        btn_n[0] = 1'b0; step(); step();
        btn_n[0] = 1'b1; step(); step();
        btn_n[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            total_cnt++;
            if (level[0] !== 1'b0)
                $display("FAIL bounce_restart_early edge=%0d got=%b exp=0", k, level[0]);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if ({level[0], press_pulse[0], toggle_state[0]} !== 3'b110)
            $display("FAIL bounce_restart_edge6 got=%b exp=110", {level[0], press_pulse[0], toggle_state[0]});
        else pass_cnt++;
        btn_n[0] = 1'b1;
        repeat (6) step();
        total_cnt++;
        if ({level[0], release_pulse[0]} !== 2'b01)
            $display("FAIL bounce_release got=%b exp=01", {level[0], release_pulse[0]});
        else pass_cnt++;
    endtask

    task automatic test_hold_repeat();
        logic exp_rep;
        logic exp_rel;
        btn_n[0] = 1'b0;
        repeat (6) step();
        total_cnt++;
        if ({press_pulse[0], toggle_state[0], repeat_pulse[0]} !== 3'b110)
            $display("FAIL hold_press got=%b exp=110", {press_pulse[0], toggle_state[0], repeat_pulse[0]});
        else pass_cnt++;
        // k counts cycles after press_pulse; button released right after k=21
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_rep = (k >= 10) && (k < 27) && (k % 5 == 0);
            exp_rel = (k == 27);
            total_cnt++;
            if (repeat_pulse[0] !== exp_rep || release_pulse[0] !== exp_rel || press_pulse[0] !== 1'b0)
                $display("FAIL hold_repeat k=%0d rep=%b rel=%b press=%b exp=%b/%b/0",
                         k, repeat_pulse[0], release_pulse[0], press_pulse[0], exp_rep, exp_rel);
            else pass_cnt++;
            if (k == 21) btn_n[0] = 1'b1;
        end
    endtask

    task automatic test_simultaneous();
        btn_n[2] = 1'b0;
        repeat (6) step();
        total_cnt++;
        if ({press_pulse[2], toggle_state[2]} !== 2'b11)
            $display("FAIL sim_ch2_press got=%b exp=11", {press_pulse[2], toggle_state[2]});
        else pass_cnt++;
        step();
        btn_n[0] = 1'b0;
        btn_n[2] = 1'b1;
        repeat (5) step();
        total_cnt++;
        if (press_pulse !== 3'b000 || release_pulse !== 3'b000)
            $display("FAIL sim_early press=%b rel=%b exp=000/000", press_pulse, release_pulse);
        else pass_cnt++;
        step();
        total_cnt++;
        if (press_pulse !== 3'b001 || release_pulse !== 3'b100 || repeat_pulse !== 3'b000)
            $display("FAIL sim_edge press=%b rel=%b rep=%b exp=001/100/000", press_pulse, release_pulse, repeat_pulse);
        else pass_cnt++;
        total_cnt++;
        if (level !== 3'b001 || toggle_state !== 3'b100)
            $display("FAIL sim_state level=%b toggle=%b exp=001/100", level, toggle_state);
        else pass_cnt++;
        btn_n[0] = 1'b1;
        repeat (6) step();
        total_cnt++;
        if (release_pulse !== 3'b001 || level !== 3'b000)
            $display("FAIL sim_ch0_release rel=%b level=%b exp=001/000", release_pulse, level);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_hold();
        btn_n[1] = 1'b0;
        repeat (6) step();
        total_cnt++;
        if ({press_pulse[1], toggle_state[1]} !== 2'b11)
            $display("FAIL mid_press got=%b exp=11", {press_pulse[1], toggle_state[1]});
        else pass_cnt++;
        repeat (10) step();
        total_cnt++;
        if (repeat_pulse[1] !== 1'b1)
            $display("FAIL mid_first_repeat got=%b exp=1", repeat_pulse[1]);
        else pass_cnt++;
        repeat (2) step();
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({level, press_pulse, release_pulse, toggle_state, repeat_pulse} !== 15'd0)
            $display("FAIL mid_async_clear got=%b exp=0", {level, press_pulse, release_pulse, toggle_state, repeat_pulse});
        else pass_cnt++;
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            total_cnt++;
            if (level[1] !== 1'b0 || toggle_state[1] !== 1'b0)
                $display("FAIL mid_repress_early edge=%0d level=%b toggle=%b exp=0/0", k, level[1], toggle_state[1]);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if ({level[1], press_pulse[1], toggle_state[1]} !== 3'b111)
            $display("FAIL mid_repress got=%b exp=111", {level[1], press_pulse[1], toggle_state[1]});
        else pass_cnt++;
        for (int k = 1; k <= 12; k++) begin
            step();
            total_cnt++;
            if (repeat_pulse[1] !== (k == 10))
                $display("FAIL mid_repeat_restart k=%0d got=%b exp=%b", k, repeat_pulse[1], (k == 10));
            else pass_cnt++;
        end
        btn_n[1] = 1'b1;
        repeat (6) step();
        total_cnt++;
        if ({level[1], release_pulse[1]} !== 2'b01)
            $display("FAIL mid_release got=%b exp=01", {level[1], release_pulse[1]});
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        btn_n     = 3'b111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
